// File: rtl/pll_reset_ce_gen.sv
// Lock qualification, core reset sequencing and single-domain clock enables
// for the 24 MHz system clock coming out of the PLL.
module pll_reset_ce_gen #(
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 16,
  parameter int DIV_6M      = 4,
  parameter int CE_NUM      = 5,
  parameter int CE_DEN      = 67
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       ext_reset,
  output logic       core_reset,
  output logic       ce_6m,
  output logic       ce_1m79,
  output logic       ce_0m89,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int DW = (DIV_6M > 1) ? $clog2(DIV_6M) : 1;
  localparam int AW = $clog2(CE_DEN + CE_NUM);

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV_6M - 1);
  localparam logic [AW-1:0] ACC_INC     = AW'(CE_NUM);
  localparam logic [AW-1:0] ACC_MOD     = AW'(CE_DEN);

  state_t          state_q;
  logic            sync1;
  logic            locked_s;
  logic [SW-1:0]   stable_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [DW-1:0]   div_cnt;
  logic [DW-1:0]   div_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   sum;
  logic            ce_wrap;
  logic            toggle;
  logic            run_next;

  assign state = state_q;

  // Two-flop synchronizer; pll_locked is asynchronous to clk_sys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  // True when the FSM will be in RUN after this edge; drives core_reset and CE gating.
  assign run_next = locked_s && !ext_reset &&
                    ((state_q == RUN) || ((state_q == HOLD) && (hold_cnt == HOLD_LAST)));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      core_reset <= ~run_next;
      case (state_q)
        WAIT_LOCK: begin
          stable_cnt <= '0;
          hold_cnt   <= '0;
          if (locked_s) state_q <= STABLE;
        end
        STABLE: begin
          if (!locked_s) begin
            state_q    <= WAIT_LOCK;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state_q    <= HOLD;
            stable_cnt <= '0;
            hold_cnt   <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state_q  <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (ext_reset) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_q  <= RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (ext_reset) begin
            state_q  <= HOLD;
            hold_cnt <= '0;
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  // The divider holds at 0 on the RUN-entry edge so RUN cycle 1 sees count 0.
  assign div_nxt = ((state_q != RUN) || (div_cnt == DIV_LAST)) ? '0 : div_cnt + 1'b1;

  // The accumulator already steps on the RUN-entry edge, so pulse k lands on RUN cycle ceil(k*DEN/NUM).
  assign sum     = acc + ACC_INC;
  assign ce_wrap = (sum >= ACC_MOD);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      acc     <= '0;
      toggle  <= 1'b0;
      ce_6m   <= 1'b0;
      ce_1m79 <= 1'b0;
      ce_0m89 <= 1'b0;
    end else if (!run_next) begin
      div_cnt <= '0;
      acc     <= '0;
      toggle  <= 1'b0;
      ce_6m   <= 1'b0;
      ce_1m79 <= 1'b0;
      ce_0m89 <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      ce_6m   <= (div_nxt == DIV_LAST);
      if (ce_wrap) begin
        acc     <= sum - ACC_MOD;
        ce_1m79 <= 1'b1;
        ce_0m89 <= toggle;
        toggle  <= ~toggle;
      end else begin
        acc     <= sum;
        ce_1m79 <= 1'b0;
        ce_0m89 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed bench for pll_reset_ce_gen: lock-up table, enable cadence and
// the lock-glitch, lock-loss, external-reset and async-reset corner cases.
module tb_pll_reset_ce_gen;

  localparam int LS = 8;
  localparam int RH = 4;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       ext_reset = 1'b0;
  logic       core_reset;
  logic       ce_6m;
  logic       ce_1m79;
  logic       ce_0m89;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pll_locked;
    logic       ext_reset;
    logic [1:0] exp_state;
    logic       exp_core_reset;
    logic       exp_ce;
  } vec_t;

  vec_t lockup_vec[15];
  vec_t v;

  int n6, n179, n089, bad6, bad179, bad089, bad_rst, longp;
  int p179[5];
  int exp179[5];
  int first6, first179;
  logic e6, e179, e089, p6, p1, p0;

  pll_reset_ce_gen #(
    .LOCK_STABLE(LS),
    .RESET_HOLD (RH)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .ext_reset (ext_reset),
    .core_reset(core_reset),
    .ce_6m     (ce_6m),
    .ce_1m79   (ce_1m79),
    .ce_0m89   (ce_0m89),
    .state     (state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic next_edge();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t vi, input string tag);
    pll_locked = vi.pll_locked;
    ext_reset  = vi.ext_reset;
    next_edge();
    check_output({tag, "_state"}, int'(state), int'(vi.exp_state));
    check_output({tag, "_core_reset"}, int'(core_reset), int'(vi.exp_core_reset));
    check_output({tag, "_ce"}, int'(ce_6m | ce_1m79 | ce_0m89), int'(vi.exp_ce));
  endtask

  task automatic run_lockup(input string tag);
    for (int i = 0; i < 15; i++)
      apply_stimulus(lockup_vec[i], $sformatf("%s_e%0d", tag, i));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_state"}, int'(state), 0);
    check_output({tag, "_core_reset"}, int'(core_reset), 1);
    check_output({tag, "_ce_6m"}, int'(ce_6m), 0);
    check_output({tag, "_ce_1m79"}, int'(ce_1m79), 0);
    check_output({tag, "_ce_0m89"}, int'(ce_0m89), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Edge i counted from the first edge sampling pll_locked=1: STABLE at 2, HOLD at 10, RUN at 14.
    for (int i = 0; i < 15; i++) begin
      lockup_vec[i].pll_locked     = 1'b1;
      lockup_vec[i].ext_reset      = 1'b0;
      lockup_vec[i].exp_state      = (i < 2) ? 2'd0 : (i < 10) ? 2'd1 : (i < 14) ? 2'd2 : 2'd3;
      lockup_vec[i].exp_core_reset = (i < 14);
      lockup_vec[i].exp_ce         = 1'b0;
    end
    exp179[0] = 14; exp179[1] = 27; exp179[2] = 41; exp179[3] = 54; exp179[4] = 67;

    #2 reset_n = 1'b0;
    next_edge();
    next_edge();
    check_reset_values("in_reset");
    reset_n = 1'b1;
    next_edge();
    next_edge();
    check_reset_values("no_lock");

    run_lockup("lockup");

    // Enable cadence over 670 RUN cycles against closed-form pulse positions.
    n6 = 0; n179 = 0; n089 = 0; bad6 = 0; bad179 = 0; bad089 = 0; bad_rst = 0; longp = 0;
    p6 = 0; p1 = 0; p0 = 0;
    for (int i = 0; i < 5; i++) p179[i] = 0;
    for (int k = 1; k <= 670; k++) begin
      if (k > 1) next_edge();
      e6   = (k % 4 == 0);
      e179 = ((5 * k) / 67) != ((5 * (k - 1)) / 67);
      e089 = e179 && (((5 * k) / 67) % 2 == 0);
      if (ce_6m !== e6) bad6++;
      if (ce_1m79 !== e179) bad179++;
      if (ce_0m89 !== e089) bad089++;
      if (core_reset !== 1'b0) bad_rst++;
      if (ce_6m) n6++;
      if (ce_1m79) begin
        if (n179 < 5) p179[n179] = k;
        n179++;
      end
      if (ce_0m89) n089++;
      if ((ce_6m && p6) || (ce_1m79 && p1) || (ce_0m89 && p0)) longp++;
      p6 = ce_6m; p1 = ce_1m79; p0 = ce_0m89;
    end
    check_output("cad_ce6m_mismatch_cycles", bad6, 0);
    check_output("cad_ce1m79_mismatch_cycles", bad179, 0);
    check_output("cad_ce0m89_mismatch_cycles", bad089, 0);
    check_output("cad_core_reset_high_cycles", bad_rst, 0);
    check_output("cad_ce6m_count", n6, 167);
    check_output("cad_ce1m79_count", n179, 50);
    check_output("cad_ce0m89_count", n089, 25);
    check_output("cad_long_pulses", longp, 0);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("cad_ce1m79_pulse%0d_cycle", i + 1), p179[i], exp179[i]);

    // Async reset between edges, during a cycle where ce_1m79/ce_0m89 are high.
    #2 reset_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    check_reset_values("async_reset");
    next_edge();
    next_edge();
    reset_n = 1'b1;
    next_edge();
    next_edge();

    // Lock glitch: three low samples in mid-STABLE, then full requalification.
    for (int i = 0; i < 5; i++)
      apply_stimulus(lockup_vec[i], $sformatf("glitch_e%0d", i));
    v = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    apply_stimulus(v, "glitch_e5");
    apply_stimulus(v, "glitch_e6");
    v.exp_state = 2'd0;
    apply_stimulus(v, "glitch_e7");
    run_lockup("relock_glitch");

    // Lock loss at RUN cycle 20: shutdown lands two edges after the first low sample.
    for (int k = 2; k <= 20; k++) next_edge();
    v = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    apply_stimulus(v, "loss_d0");
    apply_stimulus(v, "loss_d1");
    v = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    for (int i = 2; i < 7; i++)
      apply_stimulus(v, $sformatf("loss_d%0d", i));
    run_lockup("relock_loss");

    // External reset for 5 cycles at RUN cycle 100.
    for (int k = 2; k <= 100; k++) next_edge();
    v = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++)
      apply_stimulus(v, $sformatf("ext_on%0d", i));
    v = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    for (int i = 1; i < 4; i++)
      apply_stimulus(v, $sformatf("ext_off%0d", i));
    v = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    apply_stimulus(v, "ext_off4");

    first6 = 0;
    first179 = 0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) next_edge();
      if (ce_6m && first6 == 0) first6 = k;
      if (ce_1m79) begin
        first179 = k;
        break;
      end
    end
    check_output("ext_first_ce6m_cycle", first6, 4);
    check_output("ext_first_ce1m79_cycle", first179, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
